// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the
// data stage. Each access runs over a req/ack bus and has a watchdog timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ready,
    output logic              o_if_err,
    input  logic              i_d_read,
    input  logic              i_d_write,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_ready,
    output logic              o_d_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_stall
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_owner;        // 0 = fetch, 1 = data
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_d_rdata;

    logic w_d_any;
    logic w_timeout;

    assign w_d_any   = i_d_read | i_d_write;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_d_any || i_if_req) w_state_next = S_BUSY;
            S_BUSY:  if (i_mem_ack || w_timeout) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_req  = 1'b0;
        o_if_ready = 1'b0;
        o_d_ready  = 1'b0;
        o_if_err   = 1'b0;
        o_d_err    = 1'b0;
        case (r_state)
            S_BUSY: o_mem_req = 1'b1;
            S_RESP: begin
                o_if_ready = ~r_owner;
                o_d_ready  = r_owner;
                o_if_err   = ~r_owner & r_err;
                o_d_err    = r_owner & r_err;
            end
            default: ;
        endcase
    end

    // Data wins arbitration: it belongs to the older instruction in the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_d_any) begin
                        r_owner     <= 1'b1;
                        r_mem_we    <= i_d_write;
                        r_mem_addr  <= i_d_addr;
                        r_mem_wdata <= i_d_wdata;
                        r_cnt       <= CNT_W'(1);
                    end else if (i_if_req) begin
                        r_owner    <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= i_if_addr;
                        r_cnt      <= CNT_W'(1);
                    end
                end
                S_BUSY: begin
                    if (i_mem_ack) begin
                        r_err <= 1'b0;
                        if (!r_mem_we) begin
                            if (r_owner) r_d_rdata  <= i_mem_rdata;
                            else         r_if_rdata <= i_mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (!r_mem_we) begin
                            if (r_owner) r_d_rdata  <= '0;
                            else         r_if_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;
    assign o_stall     = (i_if_req & ~o_if_ready) | (w_d_any & ~o_d_ready);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipeline. It sequences each access over a variable-latency req/ack memory bus. It returns registered read data with a one-cycle ready pulse and drives the pipeline-wide stall. A watchdog terminates accesses the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max BUSY cycles waiting for mem_ack (≥2)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid with if_ready
- if_ready  out  1  one-cycle completion pulse for fetch
- if_err  out  1  with if_ready: access timed out
- d_read  in  1  load request (MemRead of MEM stage), held until d_ready
- d_write  in  1  store request (MemWrite of MEM stage), held until d_ready
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ready
- d_ready  out  1  one-cycle completion pulse for data access
- d_err  out  1  with d_ready: access timed out
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, single-cycle
- stall  out  1  pipeline stall: (if_req & ~if_ready) | ((d_read|d_write) & ~d_ready), combinational

## Operation
- FSM states: IDLE, BUSY, RESP. Owner register: 0 = IF, 1 = DATA.
- IDLE: if d_read|d_write, grant DATA. Else if if_req, grant IF. Else stay.
  - Data has fixed priority because it belongs to the older instruction.
  - On grant: latch mem_addr, mem_we (=d_write for DATA, 0 for IF), mem_wdata (d_wdata, else unchanged). Set owner. Go to BUSY.
- d_write and d_read both high: treated as a write. d_read is ignored.
- BUSY: mem_req=1. The watchdog counter counts BUSY cycles: 1 on the first BUSY cycle, incrementing each cycle.
  - mem_ack=1: capture mem_rdata into the owner's rdata register if mem_we=0. Writes leave d_rdata unchanged. Clear the error flag. Go to RESP.
  - No ack and counter == TIMEOUT: set error flag. Load 0 into the owner's rdata register if mem_we=0. Go to RESP.
  - Ack on the TIMEOUT-th cycle counts as success.
- RESP: mem_req=0. The owner's ready=1 and err=error flag, for exactly this cycle. Next state IDLE unconditionally. No grant is made in RESP.
- Requester rule: the request is held stable until ready. The requester may change or drop it on the cycle after ready.
  - Dropping a request while it is in BUSY is illegal. The transaction completes regardless.
- mem_ack in IDLE or RESP: ignored.
- if_rdata/d_rdata hold their last value between pulses.
- Reset (async, any state): IDLE, owner=0, counter=0, error=0.
  - All outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, ready and err.
  - stall follows its equation, so it is 1 while a request is high.
  - A pending memory ack after reset release is ignored, since the FSM is in IDLE.

## Timing
- Request seen in IDLE at cycle 0. mem_req rises at cycle 1.
- Ack at cycle k (k≥1) gives ready at cycle k+1. Minimum latency 2 cycles (request to ready), with ack in the first BUSY cycle.
- Timeout: mem_req is high for cycles 1..TIMEOUT. Ready with err at cycle TIMEOUT+1.
- Back-to-back: RESP at cycle n, IDLE at n+1, new grant seen at n+1, mem_req at n+2.
- stall is combinational. It is low in the ready cycle when only the completing requester is active.

## Test plan
- Single fetch: if_req=1, if_addr=0x40, ack on first BUSY cycle with mem_rdata=0x00500093 -> mem_req cycle 1 only, if_ready=1 cycle 2, if_rdata=0x00500093, stall=1 in cycles 0–1 and 0 in cycle 2.
- Contention: if_req and d_read (addr 0x100) rise together, acks after 2 cycles each -> data served first, d_ready cycle 3; fetch mem_req starts cycle 5, if_ready cycle 7; stall held until cycle 7.
- Store: d_write=1 and d_read=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF; d_ready pulse with d_rdata unchanged from its prior value.
- Timeout: TIMEOUT=16, d_read, never ack -> mem_req high exactly 16 cycles; d_ready=1 and d_err=1 on the 17th cycle; d_rdata=0. A repeat run with ack on BUSY cycle 16 -> d_err=0.
- Reset mid-BUSY: rst_n low in BUSY cycle 3 -> mem_req=0 immediately with no clock edge; ack arriving after release is ignored, with no ready pulse.
- Stray ack: mem_ack=1 while IDLE, and during RESP -> no state change and no extra ready pulse.
